// File: rtl/histogram_controller_if.sv
// Bus bundle between the histogram controller, the pixel stream, the histogram RAM
// and the display reader. master = controller side.
interface histogram_controller_if #(
  parameter int unsigned BIN_W = 20
);
  logic             frame_start;
  logic             frame_end;
  logic             pix_valid;
  logic [7:0]       pixel;
  logic [8:0]       rd_addr;
  logic [BIN_W-1:0] rd_data;
  logic             wr_en;
  logic [8:0]       wr_addr;
  logic [BIN_W-1:0] wr_data;
  logic [7:0]       histo_addr;
  logic [8:0]       disp_ram_addr;
  logic [BIN_W-1:0] peak;
  logic             busy;
  logic             overrun;

  modport master (
    input  frame_start, frame_end, pix_valid, pixel, rd_data, histo_addr,
    output rd_addr, wr_en, wr_addr, wr_data, disp_ram_addr, peak, busy, overrun
  );

  modport slave (
    output frame_start, frame_end, pix_valid, pixel, rd_data, histo_addr,
    input  rd_addr, wr_en, wr_addr, wr_data, disp_ram_addr, peak, busy, overrun
  );
endinterface

// File: rtl/histogram_controller.sv
// Luminance histogram sequencer: per-pixel read-modify-write into the accumulate bank,
// per-frame clearing, and ping-pong bank swap so the display always sees the last frame.
module histogram_controller #(
  parameter int unsigned BIN_W = 20,
  parameter int unsigned NBINS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  histogram_controller_if.master bus
);
  localparam logic [BIN_W-1:0] CNT_MAX   = '1;
  localparam logic [8:0]       LAST_ALL  = 9'(2 * NBINS - 1);
  localparam logic [8:0]       LAST_BANK = 9'(NBINS - 1);

  typedef enum logic [2:0] {CLEAR_ALL, IDLE, ACCUM, DRAIN, CLEAR} state_t;

  state_t           state, state_nx;
  logic             acc_bank, disp_bank, pend_start, ovr;
  logic [8:0]       clr_ptr;
  logic             s_valid, lw_valid;
  logic [8:0]       s_addr, lw_addr;
  logic [BIN_W-1:0] lw_data, base, acc_data, run_max, peak;
  logic             clearing;

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR_ALL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR_ALL: if (clr_ptr == LAST_ALL) state_nx = IDLE;
      IDLE:      if (bus.frame_start || pend_start) state_nx = ACCUM;
      ACCUM:     if (bus.frame_end) state_nx = DRAIN;
      DRAIN:     state_nx = CLEAR;
      CLEAR:     if (clr_ptr == LAST_BANK) state_nx = IDLE;
      default:   state_nx = CLEAR_ALL;
    endcase
  end

  // RAM returns pre-write data on a same-cycle collision, so the previous write is forwarded.
  always_comb begin
    base     = (lw_valid && lw_addr == s_addr) ? lw_data : bus.rd_data;
    acc_data = (base == CNT_MAX) ? base : base + 1'b1;
  end

  always_comb begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = s_addr;
    bus.wr_data = acc_data;
    bus.busy    = 1'b1;
    clearing    = 1'b0;
    case (state)
      CLEAR_ALL: begin
        clearing    = 1'b1;
        bus.wr_en   = ~rst;
        bus.wr_addr = clr_ptr;
        bus.wr_data = '0;
      end
      CLEAR: begin
        clearing    = 1'b1;
        bus.wr_en   = ~rst;
        bus.wr_addr = {acc_bank, clr_ptr[7:0]};
        bus.wr_data = '0;
      end
      IDLE:  bus.busy = 1'b0;
      ACCUM: begin
        bus.busy  = 1'b0;
        bus.wr_en = s_valid & ~rst;
      end
      DRAIN:   bus.wr_en = s_valid & ~rst;
      default: bus.wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_bank   <= 1'b0;
      disp_bank  <= 1'b1;
      clr_ptr    <= '0;
      pend_start <= 1'b0;
      ovr        <= 1'b0;
      peak       <= '0;
      run_max    <= '0;
      s_valid    <= 1'b0;
      lw_valid   <= 1'b0;
    end else begin
      s_valid  <= (state == ACCUM) && bus.pix_valid;
      lw_valid <= s_valid;
      if (bus.pix_valid && state != ACCUM) ovr <= 1'b1;
      if (clearing) clr_ptr <= (state_nx == IDLE) ? '0 : clr_ptr + 1'b1;
      if (bus.frame_start && (clearing || state == DRAIN)) pend_start <= 1'b1;
      else if (state == IDLE)                              pend_start <= 1'b0;
      if (s_valid && acc_data > run_max) run_max <= acc_data;
      // Swap after the DRAIN write; its value must still count toward the published peak.
      if (state == DRAIN) begin
        acc_bank  <= ~acc_bank;
        disp_bank <= ~disp_bank;
        peak      <= (s_valid && acc_data > run_max) ? acc_data : run_max;
        run_max   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    s_addr  <= {acc_bank, bus.pixel};
    lw_addr <= s_addr;
    lw_data <= acc_data;
  end

  assign bus.rd_addr       = {acc_bank, bus.pixel};
  assign bus.disp_ram_addr = {disp_bank, bus.histo_addr};
  assign bus.peak          = peak;
  assign bus.overrun       = ovr;
endmodule
